// File: rtl/memwb_skid_reg.sv
// MEM/WB pipeline register: two-entry skid buffer (head H, skid S) with flush,
// register-0 write guard, newest-first forwarding lookups and a retire counter.
module memwb_skid_reg #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int ZERO_GUARD = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_result,
    input  logic              in_s_flag,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              regbag_w_en,
    output logic [REG_AW-1:0] regbag_w_addr,
    output logic [XLEN-1:0]   regbag_w_data,
    output logic              s_flag_o,
    input  logic [REG_AW-1:0] fwd_rs1,
    input  logic [REG_AW-1:0] fwd_rs2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [XLEN-1:0]   fwd_data1,
    output logic [XLEN-1:0]   fwd_data2,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic              h_valid, h_wen, h_sflag;
    logic [REG_AW-1:0] h_rd;
    logic [XLEN-1:0]   h_result;
    logic              s_valid, s_wen, s_sflag;
    logic [REG_AW-1:0] s_rd;
    logic [XLEN-1:0]   s_result;
    logic              in_ready_q;

    logic accept, pop, in_wen;
    logic s_m1, h_m1, s_m2, h_m2;

    // Write enable is resolved once, at accept time, so the head drives the port directly.
    assign in_wen = in_wb_en & ~in_s_flag & ~((ZERO_GUARD != 0) && (in_rd == '0));
    assign accept = in_valid & in_ready_q & ~flush;
    assign pop    = h_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid    <= 1'b0;
            h_wen      <= 1'b0;
            h_sflag    <= 1'b0;
            h_rd       <= '0;
            h_result   <= '0;
            s_valid    <= 1'b0;
            s_wen      <= 1'b0;
            s_sflag    <= 1'b0;
            s_rd       <= '0;
            s_result   <= '0;
            in_ready_q <= 1'b1;
            retire_cnt <= '0;
        end else begin
            if (pop)
                retire_cnt <= retire_cnt + CNT_W'(1);
            if (flush) begin
                h_valid    <= 1'b0;
                s_valid    <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (!h_valid || (pop && !s_valid)) begin
                if (accept) begin
                    h_valid  <= 1'b1;
                    h_wen    <= in_wen;
                    h_sflag  <= in_s_flag;
                    h_rd     <= in_rd;
                    h_result <= in_result;
                end else begin
                    h_valid  <= 1'b0;
                end
                in_ready_q <= ~s_valid;
            end else if (pop) begin
                // Skid entry advances; ready returns on the following edge.
                h_valid    <= 1'b1;
                h_wen      <= s_wen;
                h_sflag    <= s_sflag;
                h_rd       <= s_rd;
                h_result   <= s_result;
                s_valid    <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (accept) begin
                s_valid    <= 1'b1;
                s_wen      <= in_wen;
                s_sflag    <= in_s_flag;
                s_rd       <= in_rd;
                s_result   <= in_result;
                in_ready_q <= 1'b0;
            end
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = h_valid;
    assign regbag_w_en   = h_valid & h_wen & out_ready;
    assign regbag_w_addr = h_rd;
    assign regbag_w_data = h_result;
    assign s_flag_o      = h_valid ? h_sflag : 1'b1;

    // S is younger than H, so it wins when both match.
    assign s_m1 = s_valid & s_wen & (s_rd == fwd_rs1);
    assign h_m1 = h_valid & h_wen & (h_rd == fwd_rs1);
    assign s_m2 = s_valid & s_wen & (s_rd == fwd_rs2);
    assign h_m2 = h_valid & h_wen & (h_rd == fwd_rs2);

    assign fwd_hit1  = s_m1 | h_m1;
    assign fwd_hit2  = s_m2 | h_m2;
    assign fwd_data1 = s_m1 ? s_result : (h_m1 ? h_result : '0);
    assign fwd_data2 = s_m2 ? s_result : (h_m2 ? h_result : '0);

endmodule

// File: tb/tb_memwb_skid_reg.sv
// Directed bench for memwb_skid_reg: a queue models the buffered entries and
// every cycle's outputs are compared against it with immediate assertions.
module tb_memwb_skid_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_wb_en = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_result = '0;
    logic        in_s_flag = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic        regbag_w_en;
    logic [4:0]  regbag_w_addr;
    logic [31:0] regbag_w_data;
    logic        s_flag_o;
    logic [4:0]  fwd_rs1 = '0;
    logic [4:0]  fwd_rs2 = '0;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic [2:0]  retire_cnt;

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        sf;
    } ent_t;

    ent_t       q[$];
    logic [2:0] expCnt = '0;
    logic       checkEn = 1'b0;
    int         total = 0;
    int         bad = 0;

    memwb_skid_reg #(.XLEN(32), .REG_AW(5), .ZERO_GUARD(1), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_wb_en(in_wb_en),
        .in_rd(in_rd), .in_result(in_result), .in_s_flag(in_s_flag),
        .out_ready(out_ready), .out_valid(out_valid),
        .regbag_w_en(regbag_w_en), .regbag_w_addr(regbag_w_addr),
        .regbag_w_data(regbag_w_data), .s_flag_o(s_flag_o),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest matching writing entry, searched from the tail of the model queue.
    function automatic logic [32:0] fwdModel(input logic [4:0] rs);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].wen && q[i].rd == rs)
                return {1'b1, q[i].res};
        return 33'd0;
    endfunction

    task automatic applyStimulus(input logic v, input logic w, input logic [4:0] rd,
                                 input logic [31:0] res, input logic sf,
                                 input logic ordy, input logic fl, input logic r);
        logic        expReady;
        logic [32:0] f1, f2;
        ent_t        e;
        @(negedge clk);
        in_valid = v; in_wb_en = w; in_rd = rd; in_result = res;
        in_s_flag = sf; out_ready = ordy; flush = fl; rst = r;
        #1;
        expReady = (q.size() < 2);
        if (checkEn) begin
            f1 = fwdModel(fwd_rs1);
            f2 = fwdModel(fwd_rs2);
            checkOutput("in_ready", in_ready, expReady);
            checkOutput("out_valid", out_valid, q.size() > 0);
            checkOutput("retire_cnt", retire_cnt, expCnt);
            checkOutput("fwd_hit1", fwd_hit1, f1[32]);
            checkOutput("fwd_data1", fwd_data1, f1[31:0]);
            checkOutput("fwd_hit2", fwd_hit2, f2[32]);
            checkOutput("fwd_data2", fwd_data2, f2[31:0]);
            if (q.size() > 0) begin
                checkOutput("s_flag_o", s_flag_o, q[0].sf);
                checkOutput("w_en", regbag_w_en, q[0].wen & ordy);
                checkOutput("w_addr", regbag_w_addr, q[0].rd);
                checkOutput("w_data", regbag_w_data, q[0].res);
            end else begin
                checkOutput("s_flag_o_empty", s_flag_o, 1'b1);
                checkOutput("w_en_empty", regbag_w_en, 1'b0);
            end
        end
        if (r) begin
            q.delete();
            expCnt = '0;
            checkEn = 1'b1;
        end else begin
            if (ordy && q.size() > 0) begin
                q.delete(0);
                expCnt = expCnt + 3'd1;
            end
            if (v && expReady && !fl) begin
                e.wen = w & ~sf & (rd != 5'd0);
                e.rd  = rd;
                e.res = res;
                e.sf  = sf;
                q.push_back(e);
            end
            if (fl)
                q.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
        checkOutput({tag, "_w_en"}, regbag_w_en, 1'b0);
        checkOutput({tag, "_w_addr"}, regbag_w_addr, 5'd0);
        checkOutput({tag, "_w_data"}, regbag_w_data, 32'd0);
        checkOutput({tag, "_s_flag_o"}, s_flag_o, 1'b1);
        checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
        checkOutput({tag, "_fwd_hit1"}, fwd_hit1, 1'b0);
        checkOutput({tag, "_fwd_data1"}, fwd_data1, 32'd0);
        checkOutput({tag, "_retire_cnt"}, retire_cnt, 3'd0);
    endtask

    initial begin
        fwd_rs1 = 5'd3;
        fwd_rs2 = 5'd4;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checkResetValues("reset");

        // Streaming: one write per cycle, S unused
        for (int i = 1; i <= 4; i++)
            applyStimulus(1, 1, 5'(i), 32'(i * 16), 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        checkOutput("stream_cnt", retire_cnt, 3'd4);

        // Skid: A, B stall; C waits until S drains
        applyStimulus(1, 1, 5'd5, 32'h55, 0, 0, 0, 0);
        applyStimulus(1, 1, 5'd6, 32'h66, 0, 0, 0, 0);
        applyStimulus(1, 1, 5'd9, 32'h99, 0, 0, 0, 0);
        checkOutput("skid_full_ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1, 5'd9, 32'h99, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        checkOutput("skid_drained", out_valid, 1'b0);

        // Suppression: stall marker and rd 0 never write but still retire
        applyStimulus(1, 1, 5'd3, 32'h33, 1, 1, 0, 0);
        applyStimulus(1, 1, 5'd0, 32'h77, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

        // Forwarding with both entries writing rd 7
        fwd_rs1 = 5'd7;
        fwd_rs2 = 5'd8;
        applyStimulus(1, 1, 5'd7, 32'hAAAA, 0, 0, 0, 0);
        applyStimulus(1, 1, 5'd7, 32'hBBBB, 0, 0, 0, 0);
        tick();
        checkOutput("fwd1_hit", fwd_hit1, 1'b1);
        checkOutput("fwd1_data", fwd_data1, 32'hBBBB);
        checkOutput("fwd2_hit", fwd_hit2, 1'b0);
        checkOutput("fwd2_data", fwd_data2, 32'd0);

        // Flush while full, together with an input
        applyStimulus(1, 1, 5'd10, 32'h1010, 0, 0, 1, 0);
        tick();
        checkOutput("flush_out_valid", out_valid, 1'b0);
        checkOutput("flush_in_ready", in_ready, 1'b1);
        checkOutput("flush_s_flag", s_flag_o, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

        // Flush with pop: head still written and counted
        applyStimulus(1, 1, 5'd11, 32'h1111, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

        // Counter wrap with CNT_W = 3
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 9; i++)
            applyStimulus(1, 1, 5'(i), 32'(i + 256), 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        checkOutput("wrap_cnt", retire_cnt, 3'd1);

        // Reset mid-operation with both entries buffered
        applyStimulus(1, 1, 5'd7, 32'hCAFE, 0, 0, 0, 0);
        applyStimulus(1, 1, 5'd12, 32'hBEEF, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checkResetValues("midreset");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
